rr_priority_arbiter: RTL and testbench
======================================

Name: rr_priority_arbiter

Overview:
- Parametrised, registered successor to the team's 4-bit combinational priority encoder.
- Accepts N request lines and issues one registered grant, as a one-hot vector plus binary index.
- Grant is held until the requester acknowledges.
- Selectable fixed-priority mode (highest index wins) or round-robin mode.
- Sits between N requesters and one shared resource.

Parameters:
- N, 8, number of request channels (N >= 2).
- IDX_W, $clog2(N), width of the encoded grant index.
- TIMEOUT, 16, grant timeout in cycles; used only with the optional feature (TIMEOUT >= 2).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- req  in  N  request vector; bit i = channel i requesting.
- rr_mode  in  1  0 = fixed priority, 1 = round-robin; sampled in IDLE only.
- ack  in  1  grant consumed; meaningful only while gnt_valid = 1.
- gnt  out  N  registered one-hot grant; all zero when no grant.
- gnt_idx  out  IDX_W  index of the granted channel; 0 when no grant.
- gnt_valid  out  1  a grant is active.
- timeout_err  out  1  present only with ARB_GRANT_TIMEOUT_EN; one-cycle pulse on forced release.

Behaviour:
- Reset (async, rst=1): state=IDLE; gnt=0, gnt_idx=0, gnt_valid=0, timeout_err=0; ptr=N-1.
- Priority order is defined by ptr: ptr is the highest-priority index, followed by ptr-1, ptr-2, … descending, wrapping N-1 after 0.
- Fixed mode: the order always starts at N-1, regardless of ptr.
- Only the single highest-priority asserted bit wins.
- States: IDLE, GRANT.
- IDLE:
  - If req == 0, stay in IDLE with outputs zero.
  - Otherwise select a winner w from req and rr_mode in this cycle.
  - Next cycle: gnt=1<<w, gnt_idx=w, gnt_valid=1, state=GRANT.
  - Latency from req to grant is 1 clock.
- GRANT:
  - gnt, gnt_idx and gnt_valid are held stable; req changes on other channels are ignored.
  - ack=1 sampled (normal release): next cycle outputs return to zero and state=IDLE. If rr_mode was 1 at arbitration, ptr becomes (w-1) mod N, so w becomes lowest priority. In fixed mode ptr is unchanged.
  - req[w]=0 sampled with ack=0 (abort): next cycle outputs return to zero, state=IDLE, ptr unchanged.
  - ack=1 and req[w]=0 in the same cycle: treated as a normal release, ptr updated.
- Minimum one IDLE cycle between grants; peak throughput is one grant per 2 cycles.
- ack while in IDLE is ignored.
- rr_mode changes during GRANT take effect at the next arbitration. ptr is retained across mode switches.
- Wrap-around: w=0 released in RR mode gives ptr=N-1.
- Reset asserted mid-GRANT clears the grant immediately (asynchronously); no pointer update occurs.
- gnt is always one-hot or zero. gnt_idx always matches gnt.

Optional Feature:
- Macro: ARB_GRANT_TIMEOUT_EN.
- When defined:
  - A $clog2(TIMEOUT)-bit counter clears on entry to GRANT and increments each GRANT cycle without ack.
  - When the count reaches TIMEOUT-1 with ack=0 and req[w]=1, the grant is force-released. Next cycle outputs return to zero, state=IDLE, and timeout_err=1 for exactly one cycle.
  - ptr is updated as for a normal release, so a stuck requester loses priority in RR mode.
  - ack in the same cycle as the timeout takes precedence: normal release, no timeout_err.
- When not defined: the timeout_err port and counter are absent, and a grant is held indefinitely until ack or abort.

Test Plan (N=4):
1. Reset, then req=4'b0000 for 5 cycles -> gnt=0000, gnt_valid=0 throughout; ack pulses ignored.
2. Fixed priority (rr_mode=0), req=1010 -> one cycle later gnt=1000, gnt_idx=3; ack -> next cycle gnt=0; req held -> gnt=1000 again (no rotation).
3. Round-robin (rr_mode=1), req=1111 held, ack each grant -> grants in order idx 3, 2, 1, 0, 3 (wrap, ptr returns to 3).
4. Abort: RR, req=0110 -> gnt=0100. Drop req[2] with ack=0 -> next cycle gnt=0. Restore req=0110 -> gnt=0100 again (ptr unchanged).
5. Async reset asserted mid-GRANT (gnt=0010) between clock edges -> gnt=0, gnt_valid=0 before the next edge. After release, req=0011 in RR -> gnt=0010 (ptr=3 order).
6. ARB_GRANT_TIMEOUT_EN, TIMEOUT=4, RR, req=0001 held, no ack -> gnt_valid high for 4 cycles, then 0 with timeout_err pulse 1 cycle. With req=1001, the next grant is idx 3; with req=0001 alone, idx 0 is re-granted.

Source files
------------

// File: rtl/rr_priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_arbiter
// Purpose  : N-way registered arbiter, fixed-priority or round-robin, grant held
//            until ack. Optional grant timeout via ARB_GRANT_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module rr_priority_arbiter #(
    parameter int N       = 8,
    parameter int IDX_W   = $clog2(N),
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             rr_mode,
    input  logic             ack,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
`ifdef ARB_GRANT_TIMEOUT_EN
    ,
    output logic             timeout_err
`endif
);

    if (N < 2) begin : g_bad_n
        $error("rr_priority_arbiter: N must be >= 2");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("rr_priority_arbiter: TIMEOUT must be >= 2");
    end

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             mode_q, mode_d;

`ifdef ARB_GRANT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terr_q, terr_d;
`endif

    logic [IDX_W-1:0] start_idx;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic [IDX_W-1:0] ptr_after_release;

    // Scan descending from the start index with wrap; first asserted request wins.
    always_comb begin
        start_idx = rr_mode ? ptr_q : IDX_W'(N - 1);
        scan_idx  = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            scan_idx = IDX_W'((int'(start_idx) + N - k) % N);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // The just-served channel becomes the lowest priority.
    assign ptr_after_release = (idx_q == '0) ? IDX_W'(N - 1) : idx_q - 1'b1;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        mode_d  = mode_q;
`ifdef ARB_GRANT_TIMEOUT_EN
        cnt_d   = cnt_q;
        terr_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d        = ST_GRANT;
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    idx_d          = win_idx;
                    valid_d        = 1'b1;
                    mode_d         = rr_mode;
`ifdef ARB_GRANT_TIMEOUT_EN
                    cnt_d          = '0;
`endif
                end
            end
            ST_GRANT: begin
                if (ack) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    if (mode_q) ptr_d = ptr_after_release;
                end else if (!req[idx_q]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
`ifdef ARB_GRANT_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    terr_d  = 1'b1;
                    if (mode_q) ptr_d = ptr_after_release;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= IDX_W'(N - 1);
            mode_q  <= 1'b0;
`ifdef ARB_GRANT_TIMEOUT_EN
            cnt_q   <= '0;
            terr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            mode_q  <= mode_d;
`ifdef ARB_GRANT_TIMEOUT_EN
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
`ifdef ARB_GRANT_TIMEOUT_EN
    assign timeout_err = terr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_priority_arbiter
// Purpose  : Self-checking bench for rr_priority_arbiter (N=4, TIMEOUT=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_rr_priority_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic         rr_mode;
    logic         ack;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_idx;
    logic         gnt_valid;
    logic         timeout_err;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    rr_priority_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rr_mode   (rr_mode),
        .ack       (ack),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
`ifdef ARB_GRANT_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );
`ifndef ARB_GRANT_TIMEOUT_EN
    assign timeout_err = 1'b0;
`endif

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_grant(input string name, input logic [3:0] eg, input logic [1:0] ei);
        check({name, ".gnt"}, {4'b0, gnt}, {4'b0, eg});
        check({name, ".idx"}, {6'b0, gnt_idx}, {6'b0, ei});
        check({name, ".valid"}, {7'b0, gnt_valid}, {7'b0, (eg != 4'b0)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Directed vectors: inputs applied before an edge, outputs expected after it.
    typedef struct {
        logic [3:0] req;
        logic       rr;
        logic       ack;
        logic [3:0] gnt;
        logic [1:0] idx;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [3:0] r, logic m, logic a, logic [3:0] g, logic [1:0] i);
        vec_t v;
        v.req = r; v.rr = m; v.ack = a; v.gnt = g; v.idx = i;
        return v;
    endfunction

    // Reference model: a priority list walked from the pointer, plus a held winner.
    int m_ptr;
    bit m_busy;
    int m_w;
    bit m_rr;
    int m_age;
    bit m_terr;

    function automatic int pick(logic [3:0] r, bit rr, int p);
        int order[$];
        int start;
        start = rr ? p : N - 1;
        for (int k = 0; k < N; k++) order.push_back((start - k + N) % N);
        foreach (order[j]) if (r[order[j]]) return order[j];
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = N - 1; m_busy = 0; m_w = 0; m_rr = 0; m_age = 0; m_terr = 0;
    endtask

    task automatic model_edge();
        int w;
        m_terr = 0;
        if (!m_busy) begin
            w = pick(req, rr_mode, m_ptr);
            if (w >= 0) begin
                m_busy = 1; m_w = w; m_rr = rr_mode; m_age = 1;
            end
        end else if (ack) begin
            m_busy = 0;
            if (m_rr) m_ptr = (m_w + N - 1) % N;
        end else if (!req[m_w]) begin
            m_busy = 0;
`ifdef ARB_GRANT_TIMEOUT_EN
        end else if (m_age == TIMEOUT) begin
            m_busy = 0; m_terr = 1;
            if (m_rr) m_ptr = (m_w + N - 1) % N;
`endif
        end else begin
            m_age++;
        end
    endtask

    initial begin
        logic [3:0] eg;
        logic [1:0] ei;

        rst = 1'b1; req = '0; rr_mode = 1'b0; ack = 1'b0;
        step();
        check_grant("reset", 4'b0000, 2'd0);
        check("reset.terr", {7'b0, timeout_err}, 8'd0);
        rst = 1'b0;

        // Idle with ack noise
        tbl.push_back(mk(4'b0000, 0, 0, 4'b0000, 0));
        tbl.push_back(mk(4'b0000, 0, 1, 4'b0000, 0));
        tbl.push_back(mk(4'b0000, 1, 1, 4'b0000, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 4'b0000, 0));
        tbl.push_back(mk(4'b0000, 1, 0, 4'b0000, 0));
        // Fixed priority, no rotation
        tbl.push_back(mk(4'b1010, 0, 0, 4'b1000, 3));
        tbl.push_back(mk(4'b1010, 0, 1, 4'b0000, 0));
        tbl.push_back(mk(4'b1010, 0, 0, 4'b1000, 3));
        tbl.push_back(mk(4'b1010, 0, 1, 4'b0000, 0));
        // Round-robin rotation 3,2,1,0,3
        tbl.push_back(mk(4'b1111, 1, 0, 4'b1000, 3));
        tbl.push_back(mk(4'b1111, 1, 1, 4'b0000, 0));
        tbl.push_back(mk(4'b1111, 1, 0, 4'b0100, 2));
        tbl.push_back(mk(4'b1111, 1, 1, 4'b0000, 0));
        tbl.push_back(mk(4'b1111, 1, 0, 4'b0010, 1));
        tbl.push_back(mk(4'b1111, 1, 1, 4'b0000, 0));
        tbl.push_back(mk(4'b1111, 1, 0, 4'b0001, 0));
        tbl.push_back(mk(4'b1111, 1, 1, 4'b0000, 0));
        tbl.push_back(mk(4'b1111, 1, 0, 4'b1000, 3));
        tbl.push_back(mk(4'b1111, 1, 1, 4'b0000, 0));
        // Abort keeps ptr; other requests ignored while granted
        tbl.push_back(mk(4'b0110, 1, 0, 4'b0100, 2));
        tbl.push_back(mk(4'b0110, 1, 0, 4'b0100, 2));
        tbl.push_back(mk(4'b0010, 1, 0, 4'b0000, 0));
        tbl.push_back(mk(4'b0110, 1, 0, 4'b0100, 2));
        tbl.push_back(mk(4'b1100, 1, 0, 4'b0100, 2));
        tbl.push_back(mk(4'b0100, 1, 1, 4'b0000, 0));
        // ack together with request drop counts as a release
        tbl.push_back(mk(4'b0110, 1, 0, 4'b0010, 1));
        tbl.push_back(mk(4'b0000, 1, 1, 4'b0000, 0));
        tbl.push_back(mk(4'b0110, 1, 0, 4'b0100, 2));
        tbl.push_back(mk(4'b0110, 1, 1, 4'b0000, 0));
        // Mode captured at arbitration, not at release
        tbl.push_back(mk(4'b1111, 1, 0, 4'b0010, 1));
        tbl.push_back(mk(4'b1111, 0, 1, 4'b0000, 0));
        tbl.push_back(mk(4'b1111, 0, 0, 4'b1000, 3));
        tbl.push_back(mk(4'b1111, 1, 1, 4'b0000, 0));
        tbl.push_back(mk(4'b0110, 1, 0, 4'b0100, 2));
        tbl.push_back(mk(4'b0110, 1, 1, 4'b0000, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            req = tbl[i].req; rr_mode = tbl[i].rr; ack = tbl[i].ack;
            step();
            check_grant($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].idx);
        end

        // Asynchronous reset in the middle of a grant (ptr is 1 here)
        req = 4'b0010; rr_mode = 1'b1; ack = 1'b0;
        step();
        check_grant("pre_rst", 4'b0010, 2'd1);
        #2 rst = 1'b1;
        #1 check_grant("async_rst", 4'b0000, 2'd0);
        #2 rst = 1'b0;
        req = 4'b0011;
        step();
        check_grant("post_rst", 4'b0010, 2'd1);
        ack = 1'b1;
        step();
        check_grant("post_rst_rel", 4'b0000, 2'd0);
        ack = 1'b0;

`ifdef ARB_GRANT_TIMEOUT_EN
        req = 4'b0001;
        for (int k = 0; k < TIMEOUT; k++) begin
            step();
            check_grant($sformatf("to_hold%0d", k), 4'b0001, 2'd0);
            check("to_hold.terr", {7'b0, timeout_err}, 8'd0);
        end
        req = 4'b1001;
        @(posedge clk); #1;
        check_grant("to_release", 4'b0000, 2'd0);
        check("to_pulse", {7'b0, timeout_err}, 8'd1);
        step();
        check_grant("to_next", 4'b1000, 2'd3);
        check("to_pulse_end", {7'b0, timeout_err}, 8'd0);
        ack = 1'b1;
        step();
        ack = 1'b0; req = 4'b0001;
        step();
        check_grant("to_regrant", 4'b0001, 2'd0);
        ack = 1'b1;
        step();
        ack = 1'b0;
`else
        req = 4'b0001;
        for (int k = 0; k < 20; k++) begin
            step();
            check_grant($sformatf("hold%0d", k), 4'b0001, 2'd0);
        end
        ack = 1'b1;
        step();
        check_grant("hold_rel", 4'b0000, 2'd0);
        ack = 1'b0;
`endif

        // Randomized run against the reference model
        rst = 1'b1; req = '0; ack = 1'b0;
        step();
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            rr_mode = ($urandom_range(0, 4) != 0);
            ack     = ($urandom_range(0, 3) == 0);
            model_edge();
            step();
            eg = m_busy ? 4'(1 << m_w) : 4'b0000;
            ei = m_busy ? 2'(m_w) : 2'd0;
            check_grant($sformatf("rnd%0d", c), eg, ei);
            check($sformatf("rnd%0d.terr", c), {7'b0, timeout_err}, {7'b0, m_terr});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
